// File: rtl/light_mode_ctrl_pkg.sv
// Shared definitions for the range-hood lighting controller: mode encodings,
// grant bit positions, default timing constants and the mode transition rule.
// No logic, no latency, no flow control.
package light_mode_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_ON   = 2'd1,
      ST_AUTO = 2'd2
   } light_state_t;

   // Bit positions inside the one-hot grant output.
   localparam int GNT_PANEL  = 0;
   localparam int GNT_REMOTE = 1;

   // Defaults sized for a 100 MHz clock.
   localparam int unsigned DEF_DEBOUNCE_CYC = 2_000_000;
   localparam int unsigned DEF_LONG_CYC     = 100_000_000;
   localparam int unsigned DEF_TICK_CYC     = 100_000_000;
   localparam int unsigned DEF_AUTO_OFF_SEC = 60;

   // Mode reached when a press event is applied in mode 'cur'.
   function automatic light_state_t next_on_event(input light_state_t cur,
                                                  input logic         is_long);
      light_state_t nxt;
      nxt = ST_OFF;
      case (cur)
         ST_OFF:  nxt = is_long ? ST_AUTO : ST_ON;
         ST_ON:   nxt = is_long ? ST_AUTO : ST_OFF;
         ST_AUTO: nxt = is_long ? ST_ON   : ST_OFF;
         default: nxt = ST_OFF;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/btn_press_classifier.sv
// Button conditioner: 2-flop sync, debounce, hold timer, short/long press pulse on release.
// Latency: 2 sync cycles + DEBOUNCE_CYC samples from raw release to a one-cycle event pulse.
// No backpressure: pulses are fire-and-forget, the consumer must take them in the cycle shown.
// Ports: clk, reset (async, active-high), btn (raw, asynchronous),
//        short_evt / long_evt (one-cycle pulses, registered).
module btn_press_classifier
   import light_mode_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned LONG_CYC     = DEF_LONG_CYC
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic short_evt,
   output logic long_evt
);

   localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int HD_W = $clog2(LONG_CYC + 1);

   logic [1:0]      sync;
   logic [1:0]      fill;     // marks when sync[1] carries a real pin sample
   logic            armed;    // pin seen low since reset
   logic            active;   // current accepted press began while armed
   logic            level;    // debounced button level
   logic [DB_W-1:0] db_cnt;
   logic [HD_W-1:0] hold;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync      <= '0;
         fill      <= '0;
         armed     <= 1'b0;
         active    <= 1'b0;
         level     <= 1'b0;
         db_cnt    <= '0;
         hold      <= '0;
         short_evt <= 1'b0;
         long_evt  <= 1'b0;
      end else begin
         sync      <= {sync[0], btn};
         fill      <= {fill[0], 1'b1};
         short_evt <= 1'b0;
         long_evt  <= 1'b0;

         // A button held through reset never arms, so its eventual release
         // is swallowed; only a fresh press after a real low counts.
         if (fill[1] && !sync[1])
            armed <= 1'b1;

         if (sync[1] != level) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
               db_cnt <= '0;
               level  <= sync[1];
               if (sync[1]) begin
                  hold   <= '0;
                  active <= armed;
               end else begin
                  if (active) begin
                     short_evt <= (hold <  HD_W'(LONG_CYC));
                     long_evt  <= (hold >= HD_W'(LONG_CYC));
                  end
                  active <= 1'b0;
               end
            end else begin
               db_cnt <= db_cnt + DB_W'(1);
            end
         end else begin
            db_cnt <= '0;
         end

         // Saturating hold timer; the rise branch above only fires while
         // level is still low, so the two writes never collide.
         if (level && hold != HD_W'(LONG_CYC))
            hold <= hold + HD_W'(1);
      end
   end

endmodule

// File: rtl/light_mode_ctrl.sv
// Range-hood lighting controller: arbitrates panel/remote presses, runs OFF/ON/AUTO with countdown.
// Latency: applied event -> light_on, auto_mode, grant registered one cycle later.
// No backpressure: a remote event colliding with a panel event is dropped, never queued.
// Ports: clk, reset (async, active-high), power_on, btn_panel, btn_remote (raw),
//        light_on, auto_mode, remaining_sec[7:0], grant[1:0] (one-hot, one cycle).
module light_mode_ctrl
   import light_mode_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
   parameter int unsigned TICK_CYC     = DEF_TICK_CYC,
   parameter int unsigned AUTO_OFF_SEC = DEF_AUTO_OFF_SEC
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       power_on,
   input  logic       btn_panel,
   input  logic       btn_remote,
   output logic       light_on,
   output logic       auto_mode,
   output logic [7:0] remaining_sec,
   output logic [1:0] grant
);

   localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

   logic pan_short, pan_long, rem_short, rem_long;

   btn_press_classifier #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
   ) u_panel (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn_panel),
      .short_evt (pan_short),
      .long_evt  (pan_long)
   );

   btn_press_classifier #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
   ) u_remote (
      .clk       (clk),
      .reset     (reset),
      .btn       (btn_remote),
      .short_evt (rem_short),
      .long_evt  (rem_long)
   );

   light_state_t  state_q, state_d;
   logic [7:0]    rem_q, rem_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [1:0]    grant_q, grant_d;
   logic          light_q, auto_q;
   logic          evt_any, evt_long;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_OFF;
         rem_q   <= '0;
         presc_q <= '0;
         grant_q <= '0;
         light_q <= 1'b0;
         auto_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         presc_q <= presc_d;
         grant_q <= grant_d;
         light_q <= (state_d != ST_OFF);
         auto_q  <= (state_d == ST_AUTO);
      end
   end

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      presc_d  = presc_q;
      grant_d  = '0;
      evt_any  = 1'b0;
      evt_long = 1'b0;

      // Panel wins a same-cycle collision.
      if (pan_short || pan_long) begin
         evt_any  = 1'b1;
         evt_long = pan_long;
      end else if (rem_short || rem_long) begin
         evt_any  = 1'b1;
         evt_long = rem_long;
      end

      if (!power_on) begin
         state_d = ST_OFF;
         rem_d   = '0;
         presc_d = '0;
      end else if (evt_any) begin
         if (pan_short || pan_long)
            grant_d[GNT_PANEL] = 1'b1;
         else
            grant_d[GNT_REMOTE] = 1'b1;
         state_d = next_on_event(state_q, evt_long);
         // Clearing the prescaler on every mode change makes the first
         // AUTO second full length; any tick this cycle is discarded.
         presc_d = '0;
         rem_d   = (state_d == ST_AUTO) ? 8'(AUTO_OFF_SEC) : 8'd0;
      end else if (state_q == ST_AUTO) begin
         if (presc_q == PW'(TICK_CYC - 1)) begin
            presc_d = '0;
            if (rem_q <= 8'd1) begin
               state_d = ST_OFF;
               rem_d   = '0;
            end else begin
               rem_d = rem_q - 8'd1;
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   assign light_on      = light_q;
   assign auto_mode     = auto_q;
   assign remaining_sec = rem_q;
   assign grant         = grant_q;

endmodule

// File: tb/tb_light_mode_ctrl.sv
module tb_light_mode_ctrl;

   localparam int DEB  = 4;
   localparam int LNG  = 20;
   localparam int TCK  = 10;
   localparam int AOS  = 3;
   // raw release -> grant: 2 sync flops + DEB samples + 1 FSM register
   localparam int EVT_LAT = 2 + DEB + 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       power_on;
   logic       btn_panel;
   logic       btn_remote;
   logic       light_on;
   logic       auto_mode;
   logic [7:0] remaining_sec;
   logic [1:0] grant;

   int   total = 0;
   int   bad   = 0;
   int   cyc;
   logic seen;

   light_mode_ctrl #(
      .DEBOUNCE_CYC (DEB),
      .LONG_CYC     (LNG),
      .TICK_CYC     (TCK),
      .AUTO_OFF_SEC (AOS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .power_on      (power_on),
      .btn_panel     (btn_panel),
      .btn_remote    (btn_remote),
      .light_on      (light_on),
      .auto_mode     (auto_mode),
      .remaining_sec (remaining_sec),
      .grant         (grant)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Step until grant appears or the budget runs out; c = edges waited.
   task automatic wait_grant(output int c);
      c = 0;
      while (grant == 2'b00 && c < 60) begin
         step();
         c++;
      end
   endtask

   task automatic quiet(input int n, output logic s);
      s = 1'b0;
      repeat (n) begin
         step();
         if (grant != 2'b00) s = 1'b1;
      end
   endtask

   task automatic panel_press(input int n);
      btn_panel = 1'b1;
      repeat (n) step();
      btn_panel = 1'b0;
   endtask

   task automatic remote_press(input int n);
      btn_remote = 1'b1;
      repeat (n) step();
      btn_remote = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      power_on   = 1'b0;
      btn_panel  = 1'b0;
      btn_remote = 1'b0;
      #12;
      chk("rst_light", light_on, 0);
      chk("rst_auto",  auto_mode, 0);
      chk("rst_rem",   remaining_sec, 0);
      chk("rst_grant", grant, 0);
      @(negedge clk);
      reset    = 1'b0;
      power_on = 1'b1;
      repeat (5) step();

      // glitch shorter than debounce window
      panel_press(3);
      quiet(20, seen);
      chk("glitch_grant", seen, 0);
      chk("glitch_light", light_on, 0);

      // short panel press OFF -> ON
      panel_press(8);
      wait_grant(cyc);
      chk("t1_lat",   cyc, EVT_LAT);
      chk("t1_grant", grant, 2'b01);
      chk("t1_light", light_on, 1);
      chk("t1_auto",  auto_mode, 0);
      step();
      chk("t1_pulse", grant, 0);

      // short again ON -> OFF
      repeat (5) step();
      panel_press(8);
      wait_grant(cyc);
      chk("on_off_grant", grant, 2'b01);
      chk("on_off_light", light_on, 0);

      // remote long OFF -> AUTO, countdown to OFF
      repeat (5) step();
      remote_press(30);
      wait_grant(cyc);
      chk("t3_lat",   cyc, EVT_LAT);
      chk("t3_grant", grant, 2'b10);
      chk("t3_light", light_on, 1);
      chk("t3_auto",  auto_mode, 1);
      chk("t3_rem3",  remaining_sec, AOS);
      repeat (TCK - 1) step();
      chk("t3_rem3_end", remaining_sec, 3);
      step();
      chk("t3_rem2", remaining_sec, 2);
      repeat (TCK) step();
      chk("t3_rem1", remaining_sec, 1);
      repeat (TCK - 1) step();
      chk("t3_still_on", light_on, 1);
      step();
      chk("t3_off_light", light_on, 0);
      chk("t3_off_rem",   remaining_sec, 0);
      chk("t3_off_auto",  auto_mode, 0);

      // get to ON, then simultaneous panel-short / remote-long
      repeat (5) step();
      panel_press(8);
      wait_grant(cyc);
      chk("t4_pre_on", light_on, 1);
      repeat (5) step();
      btn_remote = 1'b1;
      repeat (15) step();
      btn_panel = 1'b1;
      repeat (8) step();
      btn_panel  = 1'b0;
      btn_remote = 1'b0;
      wait_grant(cyc);
      chk("t4_lat",   cyc, EVT_LAT);
      chk("t4_grant", grant, 2'b01);
      chk("t4_light", light_on, 0);
      quiet(20, seen);
      chk("t4_remote_dropped", seen, 0);
      chk("t4_light_after",    light_on, 0);

      // panel long -> AUTO, remote long inside AUTO -> ON, timer cancelled
      btn_panel = 1'b1;
      repeat (20) step();
      btn_remote = 1'b1;
      repeat (5) step();
      btn_panel = 1'b0;
      wait_grant(cyc);
      chk("al_grant", grant, 2'b01);
      chk("al_auto",  auto_mode, 1);
      repeat (18) step();
      btn_remote = 1'b0;
      wait_grant(cyc);
      chk("al_on_grant", grant, 2'b10);
      chk("al_on_light", light_on, 1);
      chk("al_on_auto",  auto_mode, 0);
      chk("al_on_rem",   remaining_sec, 0);
      quiet(25, seen);
      chk("al_hold_light", light_on, 1);
      panel_press(8);
      wait_grant(cyc);
      chk("al_off_light", light_on, 0);

      // power drop in AUTO
      repeat (5) step();
      remote_press(30);
      wait_grant(cyc);
      chk("t5_auto", auto_mode, 1);
      repeat (TCK) step();
      chk("t5_rem2", remaining_sec, 2);
      power_on = 1'b0;
      step();
      chk("t5_pwr_light", light_on, 0);
      chk("t5_pwr_auto",  auto_mode, 0);
      chk("t5_pwr_rem",   remaining_sec, 0);
      panel_press(8);
      quiet(20, seen);
      chk("t5_press_dropped", seen, 0);
      chk("t5_press_light",   light_on, 0);
      power_on = 1'b1;
      repeat (3) step();
      chk("t5_up_light", light_on, 0);
      chk("t5_up_auto",  auto_mode, 0);
      panel_press(8);
      wait_grant(cyc);
      chk("t5_up_short_on", light_on, 1);

      // async reset mid-AUTO with the panel button held through it
      repeat (5) step();
      remote_press(30);
      wait_grant(cyc);
      chk("t6_auto", auto_mode, 1);
      repeat (3) step();
      btn_panel = 1'b1;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_light", light_on, 0);
      chk("t6_rst_auto",  auto_mode, 0);
      chk("t6_rst_rem",   remaining_sec, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (15) step();
      btn_panel = 1'b0;
      quiet(25, seen);
      chk("t6_held_no_evt", seen, 0);
      chk("t6_held_light",  light_on, 0);
      panel_press(8);
      wait_grant(cyc);
      chk("t6_repress_lat",   cyc, EVT_LAT);
      chk("t6_repress_grant", grant, 2'b01);
      chk("t6_repress_light", light_on, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
